// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, FSM state type and port-index type for the
// two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 5;  // 32 memory locations
  localparam int DATA_W = 8;  // byte-wide memory

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;

  // Index of one of the two requester ports.
  typedef logic port_idx_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the requester-side handshake and the memory-side
// command bus of the arbiter.
//   slave  modport: the arbiter (drives gnt/rvalid/rdata/busy and mem_*).
//   master modport: requesters plus memory (drive req/we/addr/wdata and
//                   mem_data_out).
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_data_out,
    output gnt, rvalid, rdata, busy, mem_read, mem_write, mem_addr, mem_data_in
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  gnt, rvalid, rdata, busy, mem_read, mem_write, mem_addr, mem_data_in
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : requests being considered this cycle
//   update   : a grant is issued this cycle; remember the winner
//   winner   : selected port (meaningful only when req != 0)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic [1:0] req,
  input  logic      update,
  output port_idx_t winner
);
  port_idx_t last_q, last_d;

  always_comb begin
    if (req == 2'b11) begin
      // Contention: the port that did not win most recently goes next.
      winner = ~last_q;
    end else if (req[1]) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
    last_d = update ? winner : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;  // port 0 wins the first conflict after reset
    end else begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port 32x8 synchronous memory between two
// requesters. Accepted requests become one-cycle memory commands; read data
// is captured one cycle after the command and returned to the issuing port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester handshake (req/we/addr/wdata -> gnt/rvalid/rdata/busy)
//              and memory command bus (mem_read/mem_write/mem_addr/
//              mem_data_in -> memory, mem_data_out <- memory)
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  arb_state_t        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  port_idx_t         rd_port_q, rd_port_d;

  port_idx_t winner;
  logic      grant_now;
  logic      op_write;

  assign grant_now = (state_q == IDLE) && (bus.req != 2'b00);
  assign op_write  = bus.we[winner];

  rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req),
    .update (grant_now),
    .winner (winner)
  );

  always_comb begin
    state_d       = state_q;
    gnt_d         = 2'b00;   // grant and rvalid are single-cycle pulses
    rvalid_d      = 2'b00;
    mem_read_d    = 1'b0;    // commands last exactly one cycle
    mem_write_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    rdata_d       = rdata_q;
    rd_port_d     = rd_port_q;

    unique case (state_q)
      IDLE: begin
        if (grant_now) begin
          mem_addr_d    = winner ? bus.addr1 : bus.addr0;
          mem_data_in_d = op_write ? (winner ? bus.wdata1 : bus.wdata0) : '0;
          mem_write_d   = op_write;
          mem_read_d    = ~op_write;
          gnt_d[winner] = 1'b1;
          rd_port_d     = winner;
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        // The memory executes on the edge leaving this state; only reads
        // need the extra cycle for their data to appear.
        state_d = mem_read_q ? CAPTURE : IDLE;
      end
      CAPTURE: begin
        rdata_d             = bus.mem_data_out;
        rvalid_d[rd_port_q] = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= 2'b00;
      rvalid_q      <= 2'b00;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      rdata_q       <= '0;
      rd_port_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rvalid_q      <= rvalid_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      rdata_q       <= rdata_d;
      rd_port_q     <= rd_port_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a 32x8 synchronous memory model, table-driven
// single-port transactions, hand-written multi-cycle corner cases, and a
// randomized two-port run checked against a transaction-level reference.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous memory: data appears after the edge that samples mem_read.
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_data_in;
    if (bus.mem_read)  bus.mem_data_out  <= mem[bus.mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] shadow [32];

  typedef struct {
    int port;
    bit w;
    int addr;
    int data;
    int exp;
  } vec_t;

  typedef struct {
    bit act;
    bit w;
    int addr;
    int data;
  } pend_t;

  typedef struct {
    int cyc;
    int port;
    int data;
  } rd_exp_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req = 2'b00; bus.we = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_port(input int port, input bit w, input int a, input int d);
    if (port == 0) begin
      bus.we[0] = w; bus.addr0 = a[4:0]; bus.wdata0 = d[7:0];
    end else begin
      bus.we[1] = w; bus.addr1 = a[4:0]; bus.wdata1 = d[7:0];
    end
  endtask

  // Waits (bounded) until any gnt is seen; returns cycles waited.
  task automatic wait_gnt(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.gnt == 2'b00 && lat < 8);
  endtask

  // One complete single-port transaction with latency and output checks.
  task automatic single_txn(input int port, input bit w, input int a, input int d, input int exp);
    int lat;
    set_port(port, w, a, d);
    bus.req[port] = 1'b1;
    wait_gnt(lat);
    chk($sformatf("gnt p%0d a%0d", port, a), bus.gnt, 1 << port);
    chk("gnt latency", lat, 1);
    chk("cmd {wr,rd}", {bus.mem_write, bus.mem_read}, {w, ~w});
    chk("mem_addr", bus.mem_addr, a);
    chk("mem_data_in", bus.mem_data_in, w ? d : 0);
    chk("busy at gnt", bus.busy, 1);
    bus.req[port] = 1'b0;
    if (w) begin
      @(negedge clk);
      chk("busy after write", bus.busy, 0);
      chk("write cleared", bus.mem_write, 0);
      $display("txn p%0d WR addr=%0d data=0x%02h", port, a, d);
    end else begin
      @(negedge clk);
      chk("rvalid early", bus.rvalid, 0);
      chk("busy capture", bus.busy, 1);
      @(negedge clk);
      chk("rvalid", bus.rvalid, 1 << port);
      chk($sformatf("rdata a%0d", a), bus.rdata, exp);
      chk("busy with rvalid", bus.busy, 0);
      $display("txn p%0d RD addr=%0d data=0x%02h", port, a, bus.rdata);
    end
  endtask

  // Two-port run against a transaction-level model: a grant may only happen
  // once the previous operation's occupancy (2 cycles write, 3 read) has
  // elapsed, the winner follows the round-robin rule, and each read returns
  // the shadow-memory contents two cycles after its grant.
  task automatic run_engine(input int ncyc, input bit fair_mode);
    pend_t   pend [2];
    rd_exp_t rdq [$];
    int      eval_ok = 0;
    bit      last = 1'b1;
    int      ngr = 0;
    logic [1:0] sampled;
    for (int p = 0; p < 2; p++) pend[p].act = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p].act && (fair_mode || $urandom_range(0, 2) == 0)) begin
          pend[p].act  = 1'b1;
          pend[p].w    = fair_mode ? 1'b0 : 1'($urandom_range(0, 1));
          pend[p].addr = $urandom_range(0, 31);
          pend[p].data = $urandom_range(0, 255);
        end
        set_port(p, pend[p].w, pend[p].addr, pend[p].data);
      end
      sampled = {pend[1].act, pend[0].act};
      bus.req = sampled;
      @(negedge clk);
      begin
        int exp_gnt = 0;
        int w = 0;
        int exp_rv = 0;
        int exp_rd = 0;
        if (c >= eval_ok && sampled != 2'b00) begin
          w = (sampled == 2'b11) ? int'(!last) : (sampled[1] ? 1 : 0);
          last = w[0];
          exp_gnt = 1 << w;
          if (pend[w].w) begin
            shadow[pend[w].addr] = pend[w].data[7:0];
            eval_ok = c + 2;
          end else begin
            rdq.push_back('{c + 2, w, int'(shadow[pend[w].addr])});
            eval_ok = c + 3;
          end
        end
        if (rdq.size() > 0 && rdq[0].cyc == c) begin
          exp_rv = 1 << rdq[0].port;
          exp_rd = rdq[0].data;
          void'(rdq.pop_front());
        end
        chk($sformatf("eng gnt c%0d", c), bus.gnt, exp_gnt);
        chk($sformatf("eng busy c%0d", c), bus.busy, (c <= eval_ok - 2) ? 1 : 0);
        chk($sformatf("eng rvalid c%0d", c), bus.rvalid, exp_rv);
        if (exp_rv != 0) begin
          chk($sformatf("eng rdata c%0d", c), bus.rdata, exp_rd);
          $display("txn eng RD rvalid=%0b data=0x%02h", exp_rv[1:0], exp_rd[7:0]);
        end
        if (exp_gnt != 0) begin
          chk("eng cmd", {bus.mem_write, bus.mem_read}, {pend[w].w, ~pend[w].w});
          chk("eng mem_addr", bus.mem_addr, pend[w].addr);
          chk("eng mem_data_in", bus.mem_data_in, pend[w].w ? pend[w].data : 0);
          if (fair_mode && ngr < 6) chk($sformatf("rr order #%0d", ngr), bus.gnt, 1 << (ngr % 2));
          ngr++;
          $display("txn eng GNT p%0d %s addr=%0d", w, pend[w].w ? "WR" : "RD", pend[w].addr);
          pend[w].act = 1'b0;
        end else begin
          chk("eng cmd idle", {bus.mem_write, bus.mem_read}, 0);
        end
      end
    end
    idle_inputs();
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    int g1;
    int gat;
    vecs[0] = '{0, 1'b1, 5,  'hA5, 0};
    vecs[1] = '{0, 1'b0, 5,  0,    'hA5};
    vecs[2] = '{0, 1'b1, 31, 'h3C, 0};
    vecs[3] = '{0, 1'b1, 0,  'hC3, 0};
    vecs[4] = '{0, 1'b0, 31, 0,    'h3C};
    vecs[5] = '{0, 1'b0, 0,  0,    'hC3};
    vecs[6] = '{1, 1'b0, 5,  0,    'hA5};
    vecs[7] = '{1, 1'b1, 5,  'h5A, 0};
    vecs[8] = '{0, 1'b0, 5,  0,    'h5A};

    do_reset();
    chk("reset gnt", bus.gnt, 0);
    chk("reset rvalid", bus.rvalid, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset cmd", {bus.mem_write, bus.mem_read}, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset rdata", bus.rdata, 0);

    foreach (vecs[i]) single_txn(vecs[i].port, vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].exp);

    // Reset while in CAPTURE aborts the read.
    set_port(0, 1'b0, 5, 0);
    bus.req[0] = 1'b1;
    wait_gnt(lat);
    chk("rst-mid gnt", bus.gnt, 1);
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("rst-mid busy before", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst-mid rvalid", bus.rvalid, 0);
    chk("rst-mid busy", bus.busy, 0);
    chk("rst-mid rdata", bus.rdata, 0);
    chk("rst-mid mem_addr", bus.mem_addr, 0);
    chk("rst-mid mem_data_in", bus.mem_data_in, 0);
    chk("rst-mid cmd/gnt", {bus.gnt, bus.mem_write, bus.mem_read}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst-mid no late rvalid", bus.rvalid, 0);
    $display("txn p0 RD addr=5 aborted by reset");

    // Simultaneous requests right after reset: port 0 wins.
    do_reset();
    set_port(0, 1'b1, 3, 'h11);
    set_port(1, 1'b0, 3, 0);
    bus.req = 2'b11;
    wait_gnt(lat);
    chk("sim first gnt", bus.gnt, 2'b01);
    bus.req[0] = 1'b0;
    wait_gnt(lat);
    chk("sim second gnt", bus.gnt, 2'b10);
    chk("sim second latency", lat, 2);
    bus.req[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("sim rvalid", bus.rvalid, 2'b10);
    chk("sim rdata", bus.rdata, 'h11);
    $display("txn sim p0 WR addr=3 then p1 RD addr=3 data=0x%02h", bus.rdata);

    // Port 1 holds req for 4 cycles while port 0 reads: one grant only.
    do_reset();
    set_port(0, 1'b0, 3, 0);
    bus.req[0] = 1'b1;
    wait_gnt(lat);
    chk("stab p0 gnt", bus.gnt, 2'b01);
    bus.req[0] = 1'b0;
    set_port(1, 1'b1, 7, 'h77);
    bus.req[1] = 1'b1;
    g1 = 0;
    gat = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.gnt[1]) begin
        g1++;
        gat = i;
      end
      if (i == 2) chk("stab p0 rvalid", bus.rvalid, 2'b01);
      if (i == 4) bus.req[1] = 1'b0;
    end
    chk("stab p1 grant count", g1, 1);
    chk("stab p1 grant cycle", gat, 3);
    $display("txn stab p1 WR addr=7 grants=%0d", g1);

    // Port 1: clear, read back, pattern, read back (covers 31 -> 0).
    for (int a = 0; a < 32; a++) single_txn(1, 1'b1, a, 0, 0);
    for (int a = 0; a < 32; a++) single_txn(1, 1'b0, a, 0, 0);
    for (int a = 0; a < 32; a++) single_txn(1, 1'b1, a, a, 0);
    for (int a = 0; a < 32; a++) single_txn(1, 1'b0, a, 0, a);
    for (int a = 0; a < 32; a++) shadow[a] = 8'(a);

    // Fairness: both ports hold reads continuously.
    do_reset();
    run_engine(24, 1'b1);

    // Randomized mixed traffic.
    do_reset();
    run_engine(600, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
